isa_fetch_fill: RTL and testbench

- Instruction-side line buffer between the AP instruction decoder and the DDR cache interface.
- Holds one line of ISA_DEPTH consecutive instructions. Hits are served from local RAM with 1-cycle latency.
- On a miss it issues a burst read (ins_read_req/ins_read_addr/ins_read_len) and captures the returned beats (ins_to_cache qualified by rd_burst_data_valid). It then delivers the missing instruction.
- Runs in the ui_clk domain.

---
 rtl/isa_fetch_fill_if.sv | 35 +++
 rtl/isa_fetch_fill.sv | 177 +++++++++++++++++
 tb/tb_isa_fetch_fill.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/isa_fetch_fill_if.sv
// Fetch-side and DDR-burst-side signal bundle for the instruction line buffer.
// The block drives through the slave modport; the decoder/DDR environment uses master.
interface isa_fetch_fill_if #(
    parameter int ISA_WIDTH      = 30,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int LEN_WIDTH      = 10
) ();
    logic                      init_calib_complete;
    logic                      fetch_req;
    logic [DDR_ADDR_WIDTH-1:0] fetch_addr;
    logic                      flush;
    logic [ISA_WIDTH-1:0]      ins_out;
    logic                      ins_valid;
    logic                      stall;
    logic                      ins_read_req;
    logic [DDR_ADDR_WIDTH-1:0] ins_read_addr;
    logic [LEN_WIDTH-1:0]      ins_read_len;
    logic [ISA_WIDTH-1:0]      ins_to_cache;
    logic                      rd_burst_data_valid;
    logic                      line_valid;

    modport slave (
        input  init_calib_complete, fetch_req, fetch_addr, flush,
               ins_to_cache, rd_burst_data_valid,
        output ins_out, ins_valid, stall, ins_read_req, ins_read_addr,
               ins_read_len, line_valid
    );

    modport master (
        output init_calib_complete, fetch_req, fetch_addr, flush,
               ins_to_cache, rd_burst_data_valid,
        input  ins_out, ins_valid, stall, ins_read_req, ins_read_addr,
               ins_read_len, line_valid
    );
endinterface

// File: rtl/isa_fetch_fill.sv
// Single-line instruction buffer: serves hits from local RAM in one cycle and
// refills the whole line with one DDR burst on a miss, then delivers the missed word.
module isa_fetch_fill #(
    parameter int ISA_WIDTH      = 30,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int ISA_DEPTH      = 72,
    parameter int OFS_WIDTH      = 7,
    parameter int LEN_WIDTH      = 10
) (
    input  logic             clk,
    input  logic             rst,
    isa_fetch_fill_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_CAL = 3'd1,
        REQ      = 3'd2,
        FILL     = 3'd3,
        SERVE    = 3'd4
    } state_t;

    localparam logic [DDR_ADDR_WIDTH-1:0] DEPTH_A   = DDR_ADDR_WIDTH'(ISA_DEPTH);
    localparam logic [OFS_WIDTH-1:0]      LAST_OFS  = OFS_WIDTH'(ISA_DEPTH - 1);

    state_t                    state_r;
    logic [DDR_ADDR_WIDTH-1:0] base_r;
    logic [DDR_ADDR_WIDTH-1:0] req_addr_r;
    logic [OFS_WIDTH-1:0]      fill_cnt_r;
    logic                      flush_pend_r;
    logic                      line_valid_r;
    logic [ISA_WIDTH-1:0]      ins_out_r;
    logic                      ins_valid_r;
    logic                      stall_r;
    logic                      read_req_r;
    logic [DDR_ADDR_WIDTH-1:0] read_addr_r;

    logic [ISA_WIDTH-1:0]      ram [ISA_DEPTH];

    logic [DDR_ADDR_WIDTH-1:0] diff_s;
    logic [DDR_ADDR_WIDTH-1:0] serve_diff_s;
    logic [OFS_WIDTH-1:0]      ofs_s;
    logic [OFS_WIDTH-1:0]      serve_ofs_s;
    logic                      hit_s;
    logic                      ram_we_s;
    logic [OFS_WIDTH-1:0]      ram_waddr_s;

    // Hit test; addresses below base wrap to huge differences and always miss.
    always_comb begin
        diff_s       = bus.fetch_addr - base_r;
        serve_diff_s = req_addr_r - base_r;
        ofs_s        = diff_s[OFS_WIDTH-1:0];
        serve_ofs_s  = serve_diff_s[OFS_WIDTH-1:0];
        hit_s        = line_valid_r && (bus.fetch_addr >= base_r) && (diff_s < DEPTH_A);
    end

    // RAM write port: the first beat lands while in REQ, the rest while in FILL.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = '0;
        case (state_r)
            REQ: begin
                if (bus.rd_burst_data_valid) begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = '0;
                end else begin
                    ram_we_s    = 1'b0;
                end
            end
            FILL: begin
                if (bus.rd_burst_data_valid && (fill_cnt_r <= LAST_OFS)) begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = fill_cnt_r;
                end else begin
                    ram_we_s    = 1'b0;
                end
            end
            default: ram_we_s = 1'b0;
        endcase
    end

    // Line storage, deliberately without reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram[ram_waddr_s] <= bus.ins_to_cache;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            base_r       <= '0;
            req_addr_r   <= '0;
            fill_cnt_r   <= '0;
            flush_pend_r <= 1'b0;
            line_valid_r <= 1'b0;
            ins_out_r    <= '0;
            ins_valid_r  <= 1'b0;
            stall_r      <= 1'b0;
            read_req_r   <= 1'b0;
            read_addr_r  <= '0;
        end else begin
            ins_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.flush) begin
                        line_valid_r <= 1'b0;
                    end
                    if (bus.fetch_req && hit_s) begin
                        ins_out_r   <= ram[ofs_s];
                        ins_valid_r <= 1'b1;
                    end else if (bus.fetch_req) begin
                        req_addr_r <= bus.fetch_addr;
                        stall_r    <= 1'b1;
                        state_r    <= WAIT_CAL;
                    end
                end
                WAIT_CAL: begin
                    if (bus.flush) begin
                        flush_pend_r <= 1'b1;
                    end
                    if (bus.init_calib_complete) begin
                        read_req_r  <= 1'b1;
                        read_addr_r <= req_addr_r;
                        state_r     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.flush) begin
                        flush_pend_r <= 1'b1;
                    end
                    if (bus.rd_burst_data_valid) begin
                        read_req_r <= 1'b0;
                        fill_cnt_r <= OFS_WIDTH'(1);
                        state_r    <= FILL;
                    end
                end
                FILL: begin
                    if (bus.flush) begin
                        flush_pend_r <= 1'b1;
                    end
                    if (bus.rd_burst_data_valid && (fill_cnt_r == LAST_OFS)) begin
                        base_r       <= req_addr_r;
                        line_valid_r <= !(flush_pend_r || bus.flush);
                        flush_pend_r <= 1'b0;
                        fill_cnt_r   <= '0;
                        state_r      <= SERVE;
                    end else if (bus.rd_burst_data_valid) begin
                        fill_cnt_r <= fill_cnt_r + OFS_WIDTH'(1);
                    end
                end
                SERVE: begin
                    if (bus.flush) begin
                        line_valid_r <= 1'b0;
                    end
                    ins_out_r   <= ram[serve_ofs_s];
                    ins_valid_r <= 1'b1;
                    stall_r     <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    stall_r    <= 1'b0;
                    read_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ins_out       = ins_out_r;
    assign bus.ins_valid     = ins_valid_r;
    assign bus.stall         = stall_r;
    assign bus.ins_read_req  = read_req_r;
    assign bus.ins_read_addr = read_addr_r;
    assign bus.ins_read_len  = LEN_WIDTH'(ISA_DEPTH);
    assign bus.line_valid    = line_valid_r;
endmodule

// File: tb/tb_isa_fetch_fill.sv
// Directed bench for isa_fetch_fill: a small DDR burst responder returns data equal
// to the instruction address, so every expected word is the address itself.
module tb_isa_fetch_fill;
    localparam int IW = 30;
    localparam int AW = 28;
    localparam int D  = 72;
    localparam int OW = 7;
    localparam int LW = 10;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    isa_fetch_fill_if #(.ISA_WIDTH(IW), .DDR_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    isa_fetch_fill #(
        .ISA_WIDTH(IW), .DDR_ADDR_WIDTH(AW), .ISA_DEPTH(D), .OFS_WIDTH(OW), .LEN_WIDTH(LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fetch(input logic [AW-1:0] a, input logic fl);
        @(negedge clk);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        bus.flush      = fl;
        @(negedge clk);
        bus.fetch_req  = 1'b0;
        bus.flush      = 1'b0;
    endtask

    // Waits for the burst request, returns D beats (data = address) plus extras,
    // then checks the delivered instruction and status.
    task automatic burst(input logic [AW-1:0] a, input int gaps, input int extra,
                         input int flush_at, input logic exp_lv, input string nm);
        int   sent;
        int   cyc;
        bit   seen;
        bit   got_req;
        bit   drop_chk;
        logic [IW-1:0] got_out;
        logic          got_stall;
        logic          got_lv;
        logic [IW-1:0] base_d;
        got_req = 1'b0;
        for (int i = 0; i < 30 && !got_req; i++) begin
            @(negedge clk);
            if (bus.ins_read_req === 1'b1) got_req = 1'b1;
        end
        checks++;
        if (!got_req) begin
            errors++;
            $display("FAIL %s_req: ins_read_req never rose, required 1", nm);
            return;
        end
        checks++;
        if (bus.ins_read_addr !== a || bus.ins_read_len !== LW'(D)) begin
            errors++;
            $display("FAIL %s_addr: got addr=%h len=%0d, required addr=%h len=%0d",
                     nm, bus.ins_read_addr, bus.ins_read_len, a, D);
        end
        base_d   = IW'(a);
        sent     = 0;
        cyc      = 0;
        seen     = 1'b0;
        drop_chk = 1'b0;
        got_out  = '0;
        got_stall = 1'b1;
        got_lv   = 1'b0;
        while ((sent < D + extra || !seen) && cyc < 600) begin
            if (sent < D + extra && (gaps == 0 || $urandom_range(0, 2) != 0)) begin
                bus.rd_burst_data_valid = 1'b1;
                bus.ins_to_cache = (sent < D) ? base_d + IW'(sent) : 30'h3ABC_DE00 + IW'(sent);
                bus.flush = (sent == flush_at);
                sent++;
            end else begin
                bus.rd_burst_data_valid = 1'b0;
                bus.flush = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (sent >= 1 && !drop_chk) begin
                drop_chk = 1'b1;
                checks++;
                if (bus.ins_read_req !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_req_drop: ins_read_req=%b after first beat, required 0",
                             nm, bus.ins_read_req);
                end
            end
            if (bus.ins_valid === 1'b1 && !seen) begin
                seen      = 1'b1;
                got_out   = bus.ins_out;
                got_stall = bus.stall;
                got_lv    = bus.line_valid;
            end
        end
        bus.rd_burst_data_valid = 1'b0;
        bus.flush = 1'b0;
        checks++;
        if (!seen || got_out !== base_d || got_stall !== 1'b0 || got_lv !== exp_lv) begin
            errors++;
            $display("FAIL %s_deliver: seen=%b out=%h stall=%b lv=%b, required seen=1 out=%h stall=0 lv=%b",
                     nm, seen, got_out, got_stall, got_lv, base_d, exp_lv);
        end
    endtask

    task automatic expect_hit(input logic [AW-1:0] a, input logic [IW-1:0] exp, input string nm);
        fetch(a, 1'b0);
        checks++;
        if (bus.ins_valid !== 1'b1 || bus.ins_out !== exp || bus.stall !== 1'b0
            || bus.ins_read_req !== 1'b0) begin
            errors++;
            $display("FAIL %s: valid=%b out=%h stall=%b req=%b, required valid=1 out=%h stall=0 req=0",
                     nm, bus.ins_valid, bus.ins_out, bus.stall, bus.ins_read_req, exp);
        end
    endtask

    task automatic expect_miss(input logic [AW-1:0] a, input logic fl, input string nm);
        fetch(a, fl);
        checks++;
        if (bus.stall !== 1'b1 || bus.ins_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: stall=%b valid=%b, required stall=1 valid=0",
                     nm, bus.stall, bus.ins_valid);
        end
    endtask

    task automatic test_reset;
        bit req_seen;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ins_out !== '0 || bus.ins_valid !== 1'b0 || bus.stall !== 1'b0
            || bus.ins_read_req !== 1'b0 || bus.ins_read_addr !== '0 || bus.line_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: out=%h v=%b stall=%b req=%b addr=%h lv=%b, required all 0",
                     bus.ins_out, bus.ins_valid, bus.stall, bus.ins_read_req,
                     bus.ins_read_addr, bus.line_valid);
        end
        rst = 1'b0;
        expect_miss(28'h100, 1'b0, "uncal_miss");
        req_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ins_read_req !== 1'b0) req_seen = 1'b1;
        end
        checks++;
        if (req_seen || bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL uncal_hold: req_seen=%b stall=%b, required req_seen=0 stall=1",
                     req_seen, bus.stall);
        end
        bus.init_calib_complete = 1'b1;
    endtask

    task automatic test_cold_miss;
        burst(28'h100, 0, 0, -1, 1'b1, "cold");
    endtask

    task automatic test_hits_and_misses;
        expect_hit(28'h147, 30'h147, "hit_last");
        expect_hit(28'h120, 30'h120, "hit_mid");
        expect_miss(28'h0FF, 1'b0, "miss_below");
        burst(28'h0FF, 0, 0, -1, 1'b1, "fill_0ff");
        expect_miss(28'h148, 1'b0, "miss_above");
        burst(28'h148, 0, 0, -1, 1'b1, "fill_148");
        expect_hit(28'h18F, 30'h18F, "hit_148_last");
    endtask

    task automatic test_flush;
        expect_miss(28'h200, 1'b0, "miss_200");
        burst(28'h200, 0, 0, 10, 1'b0, "flush_fill");
        expect_miss(28'h201, 1'b0, "miss_after_flush");
        burst(28'h201, 0, 0, -1, 1'b1, "fill_201");
        // Fetch and flush together: served from the pre-flush line.
        expect_hit(28'h205, 30'h205, "hit_with_flush_pre");
        fetch(28'h206, 1'b1);
        checks++;
        if (bus.ins_valid !== 1'b1 || bus.ins_out !== 30'h206 || bus.line_valid !== 1'b0) begin
            errors++;
            $display("FAIL hit_with_flush: valid=%b out=%h lv=%b, required valid=1 out=206 lv=0",
                     bus.ins_valid, bus.ins_out, bus.line_valid);
        end
        expect_miss(28'h207, 1'b0, "miss_after_idle_flush");
        burst(28'h207, 0, 0, -1, 1'b1, "fill_207");
    endtask

    task automatic test_reset_mid_fill;
        expect_miss(28'h300, 1'b0, "miss_300");
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            bus.rd_burst_data_valid = 1'b1;
            bus.ins_to_cache = 30'h300 + IW'(i);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.ins_read_addr !== '0 || bus.line_valid !== 1'b0
            || bus.ins_valid !== 1'b0 || bus.ins_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_fill: stall=%b addr=%h lv=%b v=%b out=%h, required all 0",
                     bus.stall, bus.ins_read_addr, bus.line_valid, bus.ins_valid, bus.ins_out);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 30; i < D; i++) begin
            bus.ins_to_cache = 30'h300 + IW'(i);
            @(negedge clk);
        end
        bus.rd_burst_data_valid = 1'b0;
        checks++;
        if (bus.line_valid !== 1'b0 || bus.stall !== 1'b0 || bus.ins_read_req !== 1'b0) begin
            errors++;
            $display("FAIL trailing_beats: lv=%b stall=%b req=%b, required 0 0 0",
                     bus.line_valid, bus.stall, bus.ins_read_req);
        end
        expect_miss(28'h100, 1'b0, "miss_after_reset");
        burst(28'h100, 0, 0, -1, 1'b1, "refill_100");
    endtask

    task automatic test_gaps_extra;
        expect_miss(28'h400, 1'b0, "miss_400");
        burst(28'h400, 1, 4, -1, 1'b1, "gaps");
        expect_hit(28'h447, 30'h447, "gaps_ofs71");
        expect_hit(28'h400, 30'h400, "gaps_ofs0");
    endtask

    task automatic test_wrap;
        expect_miss(28'hFFF_FFF6, 1'b0, "miss_wrap");
        burst(28'hFFF_FFF6, 0, 0, -1, 1'b1, "fill_wrap");
        expect_hit(28'hFFF_FFFF, 30'hFFF_FFFF, "hit_wrap_top");
        expect_miss(28'h000_0005, 1'b0, "wrap_low_miss");
        burst(28'h000_0005, 0, 0, -1, 1'b1, "fill_low");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.init_calib_complete = 1'b0;
        bus.fetch_req = 1'b0;
        bus.fetch_addr = '0;
        bus.flush = 1'b0;
        bus.ins_to_cache = '0;
        bus.rd_burst_data_valid = 1'b0;
        test_reset;
        test_cold_miss;
        test_hits_and_misses;
        test_flush;
        test_reset_mid_fill;
        test_gaps_extra;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
